// File: rtl/mips_pkg.sv
// Shared types for the data-memory access block.
//   state_e : access FSM states (IDLE, REQ, DONE)
//   exc_e   : exception codes reported on exc_code
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_BUSERR   = 2'b10,
    EXC_TIMEOUT  = 2'b11
  } exc_e;

endpackage

// File: rtl/access_timer.sv
// Cycle counter used to bound how long a bus request may wait for bus_ack.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (has priority over en)
//   en         : increment by one
//   tc         : terminal count, high while the count equals TIMEOUT-1
module access_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !tc) begin
      // Saturate at terminal count so the flag stays stable.
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/data_mem_access.sv
// Turns the decoder's MemRead/MemWrite strobes into one req/ack transaction
// on the data-memory bus, stalls the pipeline while it is in flight, returns
// load data and reports misaligned / bus-error / timeout exceptions.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   mem_read, mem_write  : load/store strobes (store wins if both are high)
//   addr, wdata          : byte address and store data from EX
//   stall                : combinational pipeline hold
//   rdata_out            : last successful load data
//   rdata_valid          : one-cycle pulse when rdata_out was updated
//   exc_valid, exc_code  : one-cycle exception pulse, code held until next exception
//   bus_req/we/addr/wdata: request side of the memory bus, stable while bus_req
//   bus_ack/err/rdata    : response side of the memory bus
module data_mem_access
  import mips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata_out,
  output logic              rdata_valid,
  output logic              exc_valid,
  output logic [1:0]        exc_code,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic              bus_err,
  input  logic [DATA_W-1:0] bus_rdata
);

  // Byte-offset bits within one data word; any of them set means misaligned.
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(DATA_W / 8 - 1);

  state_e            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] rdata_out_q, rdata_out_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              exc_valid_q, exc_valid_d;
  logic [1:0]        exc_code_q, exc_code_d;

  logic timer_clr;
  logic timer_en;
  logic timer_tc;
  logic access;
  logic misaligned;

  access_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (timer_clr),
    .en   (timer_en),
    .tc   (timer_tc)
  );

  assign access     = mem_read | mem_write;
  assign misaligned = |(addr & OFF_MASK);

  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    rdata_out_d   = rdata_out_q;
    rdata_valid_d = 1'b0;
    exc_valid_d   = 1'b0;
    exc_code_d    = exc_code_q;
    timer_clr     = 1'b0;
    timer_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            // No bus cycle at all; report directly.
            state_d     = DONE;
            exc_valid_d = 1'b1;
            exc_code_d  = EXC_MISALIGN;
          end else begin
            state_d     = REQ;
            bus_req_d   = 1'b1;
            // A store strobe overrides a simultaneous read strobe.
            bus_we_d    = mem_write;
            bus_addr_d  = addr & ~OFF_MASK;
            bus_wdata_d = wdata;
            timer_clr   = 1'b1;
          end
        end
      end

      REQ: begin
        if (bus_ack) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          if (bus_err) begin
            exc_valid_d = 1'b1;
            exc_code_d  = EXC_BUSERR;
          end else if (!bus_we_q) begin
            rdata_out_d   = bus_rdata;
            rdata_valid_d = 1'b1;
          end
        end else if (timer_tc) begin
          state_d     = DONE;
          bus_req_d   = 1'b0;
          exc_valid_d = 1'b1;
          exc_code_d  = EXC_TIMEOUT;
        end else begin
          timer_en = 1'b1;
        end
      end

      DONE: begin
        // Same instruction is still presented here; its strobes are ignored.
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      rdata_out_q   <= '0;
      rdata_valid_q <= 1'b0;
      exc_valid_q   <= 1'b0;
      exc_code_q    <= EXC_NONE;
    end else begin
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      rdata_out_q   <= rdata_out_d;
      rdata_valid_q <= rdata_valid_d;
      exc_valid_q   <= exc_valid_d;
      exc_code_q    <= exc_code_d;
    end
  end

  assign stall       = ((state_q == IDLE) && access) || (state_q == REQ);
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign rdata_out   = rdata_out_q;
  assign rdata_valid = rdata_valid_q;
  assign exc_valid   = exc_valid_q;
  assign exc_code    = exc_code_q;

endmodule
